pd_scan_arbiter: RTL

PD_SCAN_ARBITER -- requirements
Module: pd_scan_arbiter

---
 rtl/pd_scan_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pd_scan_arbiter.sv
// Round-robin arbiter sharing one byte-pattern detector among NCH requesters.
// Define PD_SCAN_ARB_MATCH_CNT_EN to add per-channel match counters.
module pd_scan_arbiter #(
  parameter int NCH         = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req_i,
  input  logic [NCH*8-1:0] data_i,
  input  logic [NCH-1:0]   valid_i,
  input  logic [NCH-1:0]   last_i,
  output logic [NCH-1:0]   ready_o,
  output logic [NCH-1:0]   grant_o,
  output logic [NCH-1:0]   found_o,
  input  logic [NCH-1:0]   ack_i,
  output logic             err_o,
  output logic             busy_o,
  output logic [7:0]       det_data_o,
  output logic             det_ack_o,
  output logic             det_rst_n_o,
  input  logic             det_found_i
`ifdef PD_SCAN_ARB_MATCH_CNT_EN
  ,
  output logic [NCH*16-1:0] match_cnt_o
`endif
);

  localparam int GW = $clog2(NCH);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SCAN,
    S_REPORT,
    S_RESUME,
    S_RELEASE
  } state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  g_q, g_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  pick, kk;
  logic           last_q, last_d;
  logic [15:0]    tmr_q, tmr_d;
  logic           err_q, err_d;
  logic [NCH-1:0] grant_q, ready_q, found_q;
  logic [NCH-1:0] oh_d;
  logic           busy_q, det_ack_q, det_rst_n_q;
  logic           xfer;
  int             k_sel;

  // Walk downward so the lowest offset from ptr wins.
  always_comb begin
    pick  = ptr_q;
    k_sel = 0;
    kk    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k_sel = int'(ptr_q) + i;
      if (k_sel >= NCH) k_sel = k_sel - NCH;
      kk = GW'(k_sel);
      if (req_i[kk]) pick = kk;
    end
  end

  assign xfer = (state_q == S_SCAN) && valid_i[g_q];

  assign det_data_o = xfer ? data_i[{g_q, 3'b000} +: 8]
                           : 8'h00;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          g_d     = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        last_d  = 1'b0;
        tmr_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (xfer) begin
          if (det_found_i) begin
            last_d  = last_i[g_q];
            tmr_d   = '0;
            state_d = S_REPORT;
          end else if (last_i[g_q]) begin
            state_d = S_RELEASE;
          end
        end
      end
      S_REPORT: begin
        if (ack_i[g_q]) begin
          state_d = last_q ? S_RELEASE : S_RESUME;
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_RESUME: state_d = S_SCAN;
      S_RELEASE: begin
        ptr_d   = (g_q == GW'(NCH - 1)) ? '0 : g_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oh_d = NCH'(1) << g_d;

  // Outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      ptr_q       <= '0;
      last_q      <= 1'b0;
      tmr_q       <= '0;
      err_q       <= 1'b0;
      grant_q     <= '0;
      ready_q     <= '0;
      found_q     <= '0;
      busy_q      <= 1'b0;
      det_ack_q   <= 1'b1;
      det_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      grant_q     <= (state_d != S_IDLE) ? oh_d : '0;
      ready_q     <= (state_d == S_SCAN) ? oh_d : '0;
      found_q     <= (state_d == S_REPORT) ? oh_d : '0;
      busy_q      <= (state_d != S_IDLE);
      det_ack_q   <= (state_d != S_REPORT);
      det_rst_n_q <= (state_d == S_SCAN) ||
                     (state_d == S_REPORT) ||
                     (state_d == S_RESUME);
    end
  end

  assign grant_o     = grant_q;
  assign ready_o     = ready_q;
  assign found_o     = found_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign det_ack_o   = det_ack_q;
  assign det_rst_n_o = det_rst_n_q;

`ifdef PD_SCAN_ARB_MATCH_CNT_EN
  logic [15:0] cnt_q [NCH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else if (xfer && det_found_i &&
                 cnt_q[g_q] != 16'hFFFF) begin
      cnt_q[g_q] <= cnt_q[g_q] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
    assign match_cnt_o[16*gi +: 16] = cnt_q[gi];
  end
`endif

endmodule
